// File: rtl/arbiter_age.sv
// arbiter_age: N-input single-grant arbiter that serves requesters oldest-first.
// Requesters that arrive in the same cycle are ordered round-robin from rr_q.
// A per-requester age matrix records arrival order, so requests that queue up
// while the downstream buffer is full are later served in the order they came.
// The grant is combinational: a new request can win in its arrival cycle.
module arbiter_age #(
    parameter int N   = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   request,
    input  logic           buffer_full_i,
    output logic [N-1:0]   grant,
    output logic           grant_v_o,
    output logic [IDW-1:0] grant_id_o,
    output logic [IDW:0]   pending_o
);

    // Only the lower triangle (i>j) of the age matrix is stored; bit set means i older than j.
    localparam int AW = (N * (N - 1)) / 2;

    logic [N-1:0]   tracked_q, tracked_d;
    logic [AW-1:0]  age_q, age_d;
    logic [IDW-1:0] rr_q, rr_d;

    logic [N-1:0]   trq;         // tracked and still requesting
    logic [N-1:0]   arr;         // requesting for the first time this cycle
    logic [N-1:0]   older [N];   // effective order this cycle: older[i][j] = i beats j
    logic [N-1:0]   win;
    logic           order_ok;

    // Triangle index of the unordered pair {a,b}; always in range for a != b.
    function automatic int tri_idx(input int a, input int b);
        int hi;
        int lo;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        return (hi * (hi - 1)) / 2 + lo;
    endfunction

    // Stored relation expanded to the full matrix: the upper half is the complement.
    function automatic logic stored_older(input logic [AW-1:0] a, input int i, input int j);
        return (i > j) ? a[tri_idx(i, j)] : ~a[tri_idx(i, j)];
    endfunction

    // Distance of index i from the round-robin start, scanning upward mod N.
    function automatic int rr_dist(input int i, input int r);
        return (i >= r) ? (i - r) : (i + N - r);
    endfunction

    assign trq = tracked_q & request;
    assign arr = request & ~tracked_q;

    // Build this cycle's total order over all requesters: tracked by age, then arrivals by rr scan.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            older[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (i != j) begin
                    if (trq[i] && trq[j]) begin
                        older[i][j] = stored_older(age_q, i, j);
                    end else if (trq[i] && arr[j]) begin
                        older[i][j] = 1'b1;
                    end else if (arr[i] && arr[j]) begin
                        older[i][j] = rr_dist(i, int'(rr_q)) < rr_dist(j, int'(rr_q));
                    end
                end
            end
        end
    end

    // The winner is the requester older than every other requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            win[i] = request[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && request[j] && !older[i][j]) begin
                    win[i] = 1'b0;
                end
            end
        end
    end

    assign grant     = (rst || buffer_full_i) ? '0 : win;
    assign grant_v_o = |grant;

    // Encode the one-hot grant; stays 0 when nothing is granted.
    always_comb begin
        grant_id_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_id_o = IDW'(i);
            end
        end
    end

    // Number of requesters currently holding an age entry.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < N; i++) begin
            pending_o = pending_o + {{IDW{1'b0}}, tracked_q[i]};
        end
    end

    // A granted requester drops its entry, so if it keeps requesting it re-arrives as youngest.
    assign tracked_d = request & ~grant;

    // Capture the effective order for every pair that stays requesting; others are don't-care.
    always_comb begin
        age_d = age_q;
        for (int i = 1; i < N; i++) begin
            for (int j = 0; j < i; j++) begin
                if (request[i] && request[j]) begin
                    age_d[tri_idx(i, j)] = older[i][j];
                end
            end
        end
    end

    // Tie-break start moves just past the last winner and holds when nothing is granted.
    always_comb begin
        rr_d = rr_q;
        if (grant_v_o) begin
            rr_d = (int'(grant_id_o) == N - 1) ? '0 : grant_id_o + 1'b1;
        end
    end

    // State registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            tracked_q <= '0;
            age_q     <= '0;
            rr_q      <= '0;
        end else begin
            tracked_q <= tracked_d;
            age_q     <= age_d;
            rr_q      <= rr_d;
        end
    end

    // Transitivity of the stored order over tracked entries (antisymmetry is structural).
    always_comb begin
        order_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    if (i != j && j != k && i != k &&
                        tracked_q[i] && tracked_q[j] && tracked_q[k] &&
                        stored_older(age_q, i, j) && stored_older(age_q, j, k) &&
                        !stored_older(age_q, i, k)) begin
                        order_ok = 1'b0;
                    end
                end
            end
        end
    end

    // Simulation checks of the ordering and grant invariants.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (order_ok);
            assert ($onehot0(grant));
            assert ((grant & ~request) == '0);
        end
    end

endmodule
